// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin arbiter and sequencer that shares one byte-wide
// SPI master among NUM_REQ requesters. It grants one requester, fires a
// single-cycle start with that requester's byte, waits for done or a
// timeout, and returns the received byte (or an error flag) to the winner.
module spi_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [7:0]           rsp_data,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 start,
    output logic [7:0]           data_in,
    input  logic                 done,
    input  logic [7:0]           data_out
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   win_q, win_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [7:0]         rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;
    logic               busy_q, busy_d;
    logic               start_q, start_d;
    logic [7:0]         data_in_q, data_in_d;

    logic               pick_found;
    logic [PTR_W-1:0]   pick_idx;
    logic [PTR_W-1:0]   cand_idx;
    int                 cand;

    // Round-robin search: first requesting index after ptr, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = PTR_W'(cand);
            if (!pick_found && req[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // Next-state and registered-output logic for the IDLE/ISSUE/WAIT/RESP sequence.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        busy_d      = busy_q;
        start_d     = 1'b0;
        data_in_d   = data_in_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    state_d   = S_ISSUE;
                    win_d     = pick_idx;
                    gnt_d     = NUM_REQ'(1) << pick_idx;
                    data_in_d = req_data[{pick_idx, 3'b000} +: 8];
                    start_d   = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // done has priority over a timeout landing in the same cycle
                if (done) begin
                    rsp_data_d  = data_out;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = NUM_REQ'(1) << win_q;
                    state_d     = S_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rsp_data_d  = 8'h00;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = NUM_REQ'(1) << win_q;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                // pointer moves on errors too, so a dead slave cannot hog the bus
                ptr_d   = win_q;
                gnt_d   = '0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= PTR_W'(NUM_REQ - 1);
            win_q       <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= 8'h00;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            start_q     <= 1'b0;
            data_in_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
            start_q     <= start_d;
            data_in_q   <= data_in_d;
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;
    assign start     = start_q;
    assign data_in   = data_in_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Testbench for spi_arbiter: transaction-level reference model (round-robin
// pointer, timeout rule) driving randomized requests and SPI master replies.
module tb_spi_arbiter;

    localparam int N = 4;
    localparam int T = 64;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   gnt;
    logic [N-1:0]   rsp_valid;
    logic [7:0]     rsp_data;
    logic           rsp_err;
    logic           busy;
    logic           start;
    logic [7:0]     data_in;
    logic           done = 1'b0;
    logic [7:0]     data_out = 8'h00;

    int n_checks = 0;
    int n_errors = 0;
    int ptr_m    = N - 1;

    spi_arbiter #(.NUM_REQ(N), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy), .start(start), .data_in(data_in),
        .done(done), .data_out(data_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference round-robin choice: first set bit after p, wrapping modulo N.
    function automatic int rr_pick(input int p, input logic [N-1:0] m);
        for (int i = 1; i <= N; i++) begin
            int j = (p + i) % N;
            if (m[j]) return j;
        end
        return 0;
    endfunction

    function automatic logic [8*N-1:0] rand_data();
        logic [8*N-1:0] v;
        for (int b = 0; b < N; b++) v[8*b +: 8] = 8'($urandom);
        return v;
    endfunction

    // Structural invariants sampled every cycle outside reset.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            chk("rsp_onehot0", 32'($onehot0(rsp_valid)), 32'd1);
            chk("start_without_gnt", 32'(start && (gnt == '0)), 32'd0);
        end
    end

    // One transaction starting at a negedge with the DUT in IDLE.
    // d = WAIT cycle index at which done is driven; d >= T means never.
    task automatic run_txn(input logic [N-1:0] mask, input logic [8*N-1:0] rd,
                           input int d, input logic [7:0] rbyte, input bit drop,
                           output logic [N-1:0] obs_gnt, output time start_t,
                           output time done_t);
        int  w;
        int  c;
        bit  last;
        w        = rr_pick(ptr_m, mask);
        req_data = rd;
        req      = mask;
        done     = 1'($urandom);
        data_out = 8'($urandom);
        done_t   = 0;
        @(negedge clk);
        start_t = $time;
        obs_gnt = gnt;
        chk("issue_start", 32'(start), 32'd1);
        chk("issue_gnt", 32'(gnt), 32'(1 << w));
        chk("issue_busy", 32'(busy), 32'd1);
        chk("issue_data_in", 32'(data_in), 32'(rd[8*w +: 8]));
        chk("issue_rsp_valid", 32'(rsp_valid), 32'd0);
        done = 1'($urandom);
        @(negedge clk);
        c = 0;
        while (1) begin
            if (drop && c == 0) req[w] = 1'b0;
            chk("wait_start", 32'(start), 32'd0);
            chk("wait_gnt", 32'(gnt), 32'(1 << w));
            chk("wait_busy", 32'(busy), 32'd1);
            chk("wait_rsp_valid", 32'(rsp_valid), 32'd0);
            done     = (c == d);
            data_out = (c == d) ? rbyte : 8'($urandom);
            if (c == d) done_t = $time;
            last = (c == d) || (c == T - 1);
            @(negedge clk);
            done = 1'b0;
            if (last) break;
            c++;
        end
        chk("resp_valid", 32'(rsp_valid), 32'(1 << w));
        chk("resp_data", 32'(rsp_data), (d < T) ? 32'(rbyte) : 32'd0);
        chk("resp_err", 32'(rsp_err), (d < T) ? 32'd0 : 32'd1);
        chk("resp_gnt", 32'(gnt), 32'(1 << w));
        chk("resp_busy", 32'(busy), 32'd1);
        chk("resp_start", 32'(start), 32'd0);
        ptr_m = w;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_gnt", 32'(gnt), 32'd0);
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("idle_start", 32'(start), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_start"}, 32'(start), 32'd0);
        chk({tag, "_data_in"}, 32'(data_in), 32'd0);
    endtask

    initial begin
        logic [N-1:0]   g;
        logic [8*N-1:0] rd;
        time            st, dt, prev_dt;
        int             seq[6] = '{0, 1, 2, 3, 0, 1};
        int             d;
        int             r;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_req_busy", 32'(busy), 32'd0);
        chk("idle_no_req_start", 32'(start), 32'd0);

        // Simultaneous requests: 1 then 3, second start 3 cycles after done
        run_txn(4'b1010, rand_data(), 2, 8'h11, 1'b0, g, st, dt);
        chk("pair_first", 32'(g), 32'b0010);
        prev_dt = dt;
        run_txn(4'b1010, rand_data(), 4, 8'h22, 1'b0, g, st, dt);
        chk("pair_second", 32'(g), 32'b1000);
        chk("pair_b2b_gap", 32'(st - prev_dt), 32'd30);

        // Fairness with all requesting and immediate done
        for (int i = 0; i < 6; i++) begin
            run_txn(4'b1111, rand_data(), 0, 8'($urandom), 1'b0, g, st, dt);
            chk("fair_seq", 32'(g), 32'(1 << seq[i]));
        end

        // Single request with known byte
        rd = rand_data();
        rd[7:0] = 8'hA5;
        run_txn(4'b0001, rd, 7, 8'h3C, 1'b0, g, st, dt);
        chk("single_gnt", 32'(g), 32'b0001);

        // Timeout, then pointer advanced past requester 2
        run_txn(4'b0100, rand_data(), T + 5, 8'h00, 1'b0, g, st, dt);
        chk("tmo_gnt", 32'(g), 32'b0100);
        run_txn(4'b0101, rand_data(), 1, 8'h5A, 1'b0, g, st, dt);
        chk("after_tmo_gnt", 32'(g), 32'b0001);

        // done exactly at the last WAIT cycle
        run_txn(4'b0010, rand_data(), T - 1, 8'hC3, 1'b0, g, st, dt);

        // Reset in WAIT, stray done afterwards
        req = 4'b0100;
        req_data = rand_data();
        repeat (3) @(negedge clk);
        chk("rstwait_busy_pre", 32'(busy), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("rstwait");
        rst = 1'b1;
        req = '0;
        done = 1'b1;
        data_out = 8'h77;
        @(negedge clk);
        done = 1'b0;
        chk("rstwait_idle_busy", 32'(busy), 32'd0);
        chk("rstwait_idle_rsp", 32'(rsp_valid), 32'd0);
        chk("rstwait_idle_start", 32'(start), 32'd0);
        @(negedge clk);
        chk("rstwait_idle2_busy", 32'(busy), 32'd0);
        ptr_m = N - 1;
        run_txn(4'b1010, rand_data(), 3, 8'h99, 1'b0, g, st, dt);
        chk("rstwait_next_gnt", 32'(g), 32'b0010);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            r = int'($urandom % 10);
            if (r < 6)      d = int'($urandom % 6);
            else if (r < 8) d = int'($urandom_range(6, T - 1));
            else            d = T + 5;
            run_txn(4'($urandom_range(1, 15)), rand_data(), d, 8'($urandom),
                    1'($urandom % 4 == 0), g, st, dt);
            if ($urandom % 3 == 0) begin
                req = '0;
                repeat (2) @(negedge clk);
                chk("gap_busy", 32'(busy), 32'd0);
                chk("gap_start", 32'(start), 32'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
